// File: rtl/dice_roll_requester.sv
// rtl/dice_roll_requester.sv - dice roller initiator: issues N rolls, range-checks results, accumulates sum/max/errors.
// Optional per-face histogram enabled by DICE_HIST_EN.
module dice_roll_requester #(
    parameter int ROLL_LATENCY = 2,
    parameter int CNT_W        = 8,
    parameter int SUM_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cmd_die,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             busy,
    output logic             done,
    output logic             roll,
    output logic [1:0]       die_select,
    input  logic [7:0]       rolled_number,
    output logic [SUM_W-1:0] sum,
    output logic [7:0]       max_roll,
    output logic [7:0]       err_count,
    output logic [7:0]       last_roll
`ifdef DICE_HIST_EN
    ,
    input  logic [4:0]       hist_sel,
    output logic [7:0]       hist_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ROLL_LATENCY - 1);

    state_t           state_q, state_d;
    logic [1:0]       die_q, die_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       wait_q, wait_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [7:0]       max_q, max_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       sides;
    logic             value_ok;
    logic [SUM_W:0]   sum_ext;
`ifdef DICE_HIST_EN
    logic [7:0]       hist_q [20];
    logic [7:0]       hist_d [20];
`endif

    always_comb begin
        case (die_q)
            2'b00:   sides = 8'd4;
            2'b01:   sides = 8'd6;
            2'b10:   sides = 8'd8;
            default: sides = 8'd20;
        endcase
    end

    assign value_ok = (rolled_number != 8'd0) && (rolled_number <= sides);
    assign sum_ext  = {1'b0, sum_q} + {{(SUM_W + 1 - 8){1'b0}}, rolled_number};

    always_comb begin
        state_d     = state_q;
        die_d       = die_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        sum_d       = sum_q;
        max_d       = max_q;
        err_d       = err_q;
        last_d      = last_q;
`ifdef DICE_HIST_EN
        for (int i = 0; i < 20; i++) hist_d[i] = hist_q[i];
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    die_d       = cmd_die;
                    remaining_d = cmd_count;
                    sum_d       = '0;
                    max_d       = '0;
                    err_d       = '0;
`ifdef DICE_HIST_EN
                    for (int i = 0; i < 20; i++) hist_d[i] = '0;
`endif
                    state_d = (cmd_count == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    // Sample edge: the roller's result is valid this cycle.
                    last_d = rolled_number;
                    if (value_ok) begin
                        sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                        if (rolled_number > max_q) max_d = rolled_number;
`ifdef DICE_HIST_EN
                        for (int i = 0; i < 20; i++) begin
                            if (rolled_number == 8'(i + 1) && hist_q[i] != 8'hFF)
                                hist_d[i] = hist_q[i] + 8'd1;
                        end
`endif
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q != CNT_W'(1)) ? S_ISSUE : S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            die_q       <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            err_q       <= '0;
            last_q      <= '0;
`ifdef DICE_HIST_EN
            for (int i = 0; i < 20; i++) hist_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            die_q       <= die_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            err_q       <= err_d;
            last_q      <= last_d;
`ifdef DICE_HIST_EN
            for (int i = 0; i < 20; i++) hist_q[i] <= hist_d[i];
`endif
        end
    end

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done       = (state_q == S_FINISH);
    assign roll       = (state_q == S_ISSUE);
    assign die_select = die_q;
    assign sum        = sum_q;
    assign max_roll   = max_q;
    assign err_count  = err_q;
    assign last_roll  = last_q;

`ifdef DICE_HIST_EN
    always_comb begin
        hist_count = '0;
        if (hist_sel >= 5'd1 && hist_sel <= 5'd20) hist_count = hist_q[hist_sel - 5'd1];
    end
`endif

endmodule

// File: tb/tb_dice_roll_requester.sv
// tb/tb_dice_roll_requester.sv - self-checking bench for dice_roll_requester with a roller model and result model.
module tb_dice_roll_requester;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cmd_die = '0;
    logic [7:0]  cmd_count = '0;
    logic        busy, done, roll;
    logic [1:0]  die_select;
    logic [7:0]  rolled_number = '0;
    logic [15:0] sum;
    logic [7:0]  max_roll, err_count, last_roll;
`ifdef DICE_HIST_EN
    logic [4:0]  hist_sel = '0;
    logic [7:0]  hist_count;
`endif

    dice_roll_requester #(.ROLL_LATENCY(L), .CNT_W(8), .SUM_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_die(cmd_die), .cmd_count(cmd_count),
        .busy(busy), .done(done), .roll(roll), .die_select(die_select),
        .rolled_number(rolled_number), .sum(sum), .max_roll(max_roll),
        .err_count(err_count), .last_roll(last_roll)
`ifdef DICE_HIST_EN
        , .hist_sel(hist_sel), .hist_count(hist_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vals [0:255];
    int roll_cyc [$];
    int done_cyc, done_cnt;
    bit sel_changed, busy_bad;
    logic       rst_roll, rst_busy;
    logic [15:0] rst_sum;

    // Roller model: the k-th roll's value is presented L cycles after its pulse, junk otherwise.
    task automatic run_cmd(input logic [1:0] die, input int n, input int restart_cyc,
                           input int reset_cyc, input int max_cyc);
        int exp_done;
        exp_done = (n == 0) ? 1 : n * (L + 1) + 1;
        roll_cyc.delete();
        done_cyc = -1; done_cnt = 0; sel_changed = 0; busy_bad = 0;
        @(posedge clk); #1;
        start = 1'b1; cmd_die = die; cmd_count = 8'(n); rolled_number = 8'($urandom);
        for (int t = 1; t <= max_cyc; t++) begin
            @(posedge clk); #1;
            start = 1'b0; reset = 1'b0;
            cmd_die = 2'($urandom); cmd_count = 8'($urandom);
            if (t == restart_cyc) begin start = 1'b1; cmd_die = 2'b00; end
            if (t == reset_cyc) reset = 1'b1;
            if (roll === 1'b1) roll_cyc.push_back(t);
            if (done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = t; end
            if (reset_cyc < 0) begin
                if (die_select !== die) sel_changed = 1;
                if (busy !== (t < exp_done)) busy_bad = 1;
            end
            if (t == reset_cyc + 1) begin rst_roll = roll; rst_busy = busy; rst_sum = sum; end
            rolled_number = 8'($urandom);
            foreach (roll_cyc[k]) if (roll_cyc[k] + L == t && k < n) rolled_number = 8'(vals[k]);
            if (done_cyc >= 0 && reset_cyc < 0 && t >= done_cyc + 2) break;
        end
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic model(input logic [1:0] die, input int n, output int es, output int em,
                         output int ee, output int el);
        int sides;
        sides = (die == 0) ? 4 : (die == 1) ? 6 : (die == 2) ? 8 : 20;
        es = 0; em = 0; ee = 0; el = 0;
        for (int k = 0; k < n; k++) begin
            el = vals[k];
            if (vals[k] >= 1 && vals[k] <= sides) begin
                es = (es + vals[k] > 65535) ? 65535 : es + vals[k];
                if (vals[k] > em) em = vals[k];
            end else if (ee < 255) ee++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (roll !== 1'b0) begin errors++; $display("FAIL reset_roll got %0b want 0", roll); end
        checks++; if (die_select !== 2'b00) begin errors++; $display("FAIL reset_die got %0d want 0", die_select); end
        checks++; if (sum !== 16'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", sum); end
        checks++; if (max_roll !== 8'd0) begin errors++; $display("FAIL reset_max got %0d want 0", max_roll); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
        checks++; if (last_roll !== 8'd0) begin errors++; $display("FAIL reset_last got %0d want 0", last_roll); end
    endtask

    task automatic test_d4_basic();
        vals[0] = 1; vals[1] = 4; vals[2] = 3;
        run_cmd(2'b00, 3, -1, -1, 40);
        checks++; if (roll_cyc.size() != 3) begin errors++; $display("FAIL d4_roll_count got %0d want 3", roll_cyc.size()); end
        for (int k = 0; k < 3 && k < roll_cyc.size(); k++) begin
            checks++;
            if (roll_cyc[k] != 1 + 3 * k) begin errors++; $display("FAIL d4_roll_cycle[%0d] got %0d want %0d", k, roll_cyc[k], 1 + 3 * k); end
        end
        checks++; if (done_cyc != 10) begin errors++; $display("FAIL d4_done_cycle got %0d want 10", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL d4_done_pulses got %0d want 1", done_cnt); end
        checks++; if (busy_bad) begin errors++; $display("FAIL d4_busy_window got bad want good"); end
        checks++; if (sel_changed) begin errors++; $display("FAIL d4_die_stable got changed want 00"); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sum !== 16'd8) begin errors++; $display("FAIL d4_sum got %0d want 8", sum); end
        checks++; if (max_roll !== 8'd4) begin errors++; $display("FAIL d4_max got %0d want 4", max_roll); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL d4_err got %0d want 0", err_count); end
        checks++; if (last_roll !== 8'd3) begin errors++; $display("FAIL d4_last got %0d want 3", last_roll); end
    endtask

    task automatic test_range_errors();
        vals[0] = 6; vals[1] = 0; vals[2] = 7; vals[3] = 2;
        run_cmd(2'b01, 4, -1, -1, 40);
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL d6_done_cycle got %0d want 13", done_cyc); end
        checks++; if (sum !== 16'd8) begin errors++; $display("FAIL d6_sum got %0d want 8", sum); end
        checks++; if (max_roll !== 8'd6) begin errors++; $display("FAIL d6_max got %0d want 6", max_roll); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL d6_err got %0d want 2", err_count); end
        checks++; if (last_roll !== 8'd2) begin errors++; $display("FAIL d6_last got %0d want 2", last_roll); end
    endtask

    task automatic test_zero_count();
        run_cmd(2'b11, 0, -1, -1, 20);
        checks++; if (roll_cyc.size() != 0) begin errors++; $display("FAIL zero_rolls got %0d want 0", roll_cyc.size()); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
        checks++; if (sum !== 16'd0) begin errors++; $display("FAIL zero_sum got %0d want 0", sum); end
        checks++; if (max_roll !== 8'd0) begin errors++; $display("FAIL zero_max got %0d want 0", max_roll); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL zero_err got %0d want 0", err_count); end
    endtask

    task automatic test_start_while_busy();
        vals[0] = 20; vals[1] = 13;
        run_cmd(2'b11, 2, 3, -1, 40);
        checks++; if (roll_cyc.size() != 2) begin errors++; $display("FAIL busy_start_rolls got %0d want 2", roll_cyc.size()); end
        checks++; if (sel_changed) begin errors++; $display("FAIL busy_start_die got changed want 3"); end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL busy_start_done got %0d want 7", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", done_cnt); end
        checks++; if (sum !== 16'd33) begin errors++; $display("FAIL busy_start_sum got %0d want 33", sum); end
    endtask

    task automatic test_mid_reset();
        int late;
        vals[0] = 8; vals[1] = 7; vals[2] = 5; vals[3] = 1; vals[4] = 2;
        run_cmd(2'b10, 5, -1, 5, 30);
        late = 0;
        foreach (roll_cyc[k]) if (roll_cyc[k] > 5) late++;
        checks++; if (rst_roll !== 1'b0) begin errors++; $display("FAIL rst_roll got %0b want 0", rst_roll); end
        checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", rst_busy); end
        checks++; if (rst_sum !== 16'd0) begin errors++; $display("FAIL rst_sum got %0d want 0", rst_sum); end
        checks++; if (late != 0) begin errors++; $display("FAIL rst_late_rolls got %0d want 0", late); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_done got %0d want 0", done_cnt); end
        checks++; if (die_select !== 2'b00) begin errors++; $display("FAIL rst_die got %0d want 0", die_select); end
    endtask

    task automatic test_random(input int iters, input int nmin, input int nmax);
        int n, es, em, ee, el, exp_done;
        logic [1:0] die;
        for (int it = 0; it < iters; it++) begin
            die = 2'($urandom);
            n = $urandom_range(nmin, nmax);
            for (int k = 0; k < n; k++) vals[k] = $urandom_range(0, 24);
            model(die, n, es, em, ee, el);
            exp_done = (n == 0) ? 1 : n * (L + 1) + 1;
            run_cmd(die, n, -1, -1, exp_done + 10);
            checks++; if (roll_cyc.size() != n) begin errors++; $display("FAIL rnd%0d_rolls got %0d want %0d", it, roll_cyc.size(), n); end
            checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL rnd%0d_done got %0d want %0d", it, done_cyc, exp_done); end
            checks++; if (busy_bad || sel_changed) begin errors++; $display("FAIL rnd%0d_busy_die got bad want good", it); end
            checks++; if (sum !== 16'(es)) begin errors++; $display("FAIL rnd%0d_sum got %0d want %0d", it, sum, es); end
            checks++; if (max_roll !== 8'(em)) begin errors++; $display("FAIL rnd%0d_max got %0d want %0d", it, max_roll, em); end
            checks++; if (err_count !== 8'(ee)) begin errors++; $display("FAIL rnd%0d_err got %0d want %0d", it, err_count, ee); end
            if (n > 0) begin
                checks++; if (last_roll !== 8'(el)) begin errors++; $display("FAIL rnd%0d_last got %0d want %0d", it, last_roll, el); end
            end
        end
    endtask

`ifdef DICE_HIST_EN
    task automatic test_hist();
        vals[0] = 2; vals[1] = 2; vals[2] = 4; vals[3] = 5;
        run_cmd(2'b00, 4, -1, -1, 40);
        hist_sel = 5'd2; #1;
        checks++; if (hist_count !== 8'd2) begin errors++; $display("FAIL hist_2 got %0d want 2", hist_count); end
        hist_sel = 5'd4; #1;
        checks++; if (hist_count !== 8'd1) begin errors++; $display("FAIL hist_4 got %0d want 1", hist_count); end
        hist_sel = 5'd5; #1;
        checks++; if (hist_count !== 8'd0) begin errors++; $display("FAIL hist_5 got %0d want 0", hist_count); end
        hist_sel = 5'd0; #1;
        checks++; if (hist_count !== 8'd0) begin errors++; $display("FAIL hist_0 got %0d want 0", hist_count); end
        hist_sel = 5'd21; #1;
        checks++; if (hist_count !== 8'd0) begin errors++; $display("FAIL hist_21 got %0d want 0", hist_count); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL hist_err got %0d want 1", err_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_d4_basic();
        test_range_errors();
        test_zero_count();
        test_start_while_busy();
        test_mid_reset();
        test_random(12, 0, 6);
        test_random(1, 255, 255);
`ifdef DICE_HIST_EN
        test_hist();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
